// File: rtl/dm_dmi_responder.sv
// dm_dmi_responder
//   Debug Module side of the DMI. It accepts one request at a time from the
//   debug transport and returns exactly one response per request. It owns the
//   dmcontrol, dmstatus, abstractcs, command, sbcs and data0/data1 registers.
//   It also drives the single-hart halt/resume handshake and ndmreset.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   dmi_req_*          request channel (valid/ready, addr, op, data)
//   dmi_resp_*         response channel (valid/ready, data, op)
//   hart_halted        hart status input: hart is in debug mode
//   hart_running       hart status input: hart is executing normally
//   hart_resumeack     one-cycle pulse from the hart: it has resumed
//   hart_haltreq       level halt request (stored dmcontrol.haltreq)
//   hart_resumereq     resume request, held until the hart acknowledges it
//   ndmreset           dmcontrol.ndmreset
//   dmactive           dmcontrol.dmactive
module dm_dmi_responder #(
  parameter int ABITS     = 7,
  parameter int DATACOUNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dmi_req_valid,
  output logic             dmi_req_ready,
  input  logic [ABITS-1:0] dmi_req_addr,
  input  logic [1:0]       dmi_req_op,
  input  logic [31:0]      dmi_req_data,
  output logic             dmi_resp_valid,
  input  logic             dmi_resp_ready,
  output logic [31:0]      dmi_resp_data,
  output logic [1:0]       dmi_resp_op,
  input  logic             hart_halted,
  input  logic             hart_running,
  input  logic             hart_resumeack,
  output logic             hart_haltreq,
  output logic             hart_resumereq,
  output logic             ndmreset,
  output logic             dmactive
);

  localparam logic [ABITS-1:0] ADDR_DATA0      = ABITS'(7'h04);
  localparam logic [ABITS-1:0] ADDR_DATA1      = ABITS'(7'h05);
  localparam logic [ABITS-1:0] ADDR_DMCONTROL  = ABITS'(7'h10);
  localparam logic [ABITS-1:0] ADDR_DMSTATUS   = ABITS'(7'h11);
  localparam logic [ABITS-1:0] ADDR_ABSTRACTCS = ABITS'(7'h16);
  localparam logic [ABITS-1:0] ADDR_COMMAND    = ABITS'(7'h17);
  localparam logic [ABITS-1:0] ADDR_SBCS       = ABITS'(7'h38);

  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_RESERVED = 2'd3;
  localparam logic [1:0] RESP_OK     = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd2;

  localparam logic [31:0] DMCONTROL_WMASK = 32'hFFFF_FFFF;
  // resumereq(30), ackhavereset(28), ackunavail(27), setkeepalive(5),
  // clrkeepalive(4), setresethaltreq(3) and clrresethaltreq(2) are command
  // strobes. They are acted on at write time and never stored.
  localparam logic [31:0] DMCONTROL_WO    = 32'h5800_003C;
  localparam logic [31:0] SBCS_WMASK      = 32'h001F_1000;

  typedef enum logic {S_IDLE, S_RESP} xact_state_e;
  typedef enum logic {R_IDLE, R_REQ}  resume_state_e;

  xact_state_e   xact_state_reg, xact_state_next;
  resume_state_e resume_state_reg, resume_state_next;

  logic [31:0] resp_data_reg, resp_data_next;
  logic [1:0]  resp_op_reg, resp_op_next;
  logic        resumeack_reg, resumeack_next;
  logic [31:0] dmcontrol_reg, dmcontrol_next;
  logic [2:0]  cmderr_reg, cmderr_next;
  logic        relaxedpriv_reg, relaxedpriv_next;
  logic [31:0] command_reg, command_next;
  logic [31:0] sbcs_reg, sbcs_next;

  logic [DATACOUNT-1:0][31:0] data_q;

  logic        accept, do_write;
  logic        dmcontrol_wr, abstractcs_wr, command_wr, sbcs_wr;
  logic        dm_clear, resume_start;
  logic [31:0] dmstatus_val, abstractcs_val, rdata;

  assign accept        = dmi_req_valid && (xact_state_reg == S_IDLE);
  assign do_write      = accept && (dmi_req_op == OP_WRITE);
  assign dmcontrol_wr  = do_write && (dmi_req_addr == ADDR_DMCONTROL);
  assign abstractcs_wr = do_write && (dmi_req_addr == ADDR_ABSTRACTCS);
  assign command_wr    = do_write && (dmi_req_addr == ADDR_COMMAND);
  assign sbcs_wr       = do_write && (dmi_req_addr == ADDR_SBCS);

  // Any dmcontrol write with dmactive=0 puts the debug module back into its
  // inactive state, whatever dmactive was before the write.
  assign dm_clear = dmcontrol_wr && !dmi_req_data[0];

  // Resume is only requested by an active module, to a halted hart, and never
  // together with haltreq. The request must also keep dmactive set.
  assign resume_start = dmcontrol_wr && dmcontrol_reg[0] && dmi_req_data[0] &&
                        dmi_req_data[30] && !dmi_req_data[31] && hart_halted;

  // ---------------------------------------------------------------- status
  always_comb begin
    dmstatus_val        = '0;
    dmstatus_val[3:0]   = 4'd2;          // version
    dmstatus_val[7]     = 1'b1;          // authenticated
    dmstatus_val[8]     = hart_halted;   // anyhalted
    dmstatus_val[9]     = hart_halted;   // allhalted
    dmstatus_val[10]    = hart_running;  // anyrunning
    dmstatus_val[11]    = hart_running;  // allrunning
    dmstatus_val[16]    = resumeack_reg; // anyresumeack
    dmstatus_val[17]    = resumeack_reg; // allresumeack
  end

  always_comb begin
    abstractcs_val       = '0;
    abstractcs_val[3:0]  = 4'(DATACOUNT);
    abstractcs_val[10:8] = cmderr_reg;
    abstractcs_val[11]   = relaxedpriv_reg;
  end

  always_comb begin
    rdata = '0;
    case (dmi_req_addr)
      ADDR_DATA0:      rdata = data_q[0];
      ADDR_DATA1:      rdata = (DATACOUNT == 2) ? data_q[DATACOUNT-1] : '0;
      ADDR_DMCONTROL:  rdata = dmcontrol_reg;
      ADDR_DMSTATUS:   rdata = dmstatus_val;
      ADDR_ABSTRACTCS: rdata = abstractcs_val;
      ADDR_COMMAND:    rdata = command_reg;
      ADDR_SBCS:       rdata = sbcs_reg;
      default:         rdata = '0;
    endcase
  end

  // ----------------------------------------------------- transaction FSM
  always_comb begin
    xact_state_next = xact_state_reg;
    resp_data_next  = resp_data_reg;
    resp_op_next    = resp_op_reg;
    case (xact_state_reg)
      S_IDLE: begin
        if (dmi_req_valid) begin
          xact_state_next = S_RESP;
          resp_data_next  = (dmi_req_op == OP_READ) ? rdata : '0;
          resp_op_next    = (dmi_req_op == OP_RESERVED) ? RESP_FAILED : RESP_OK;
        end
      end
      S_RESP: begin
        if (dmi_resp_ready) xact_state_next = S_IDLE;
      end
      default: xact_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------- resume FSM
  always_comb begin
    resume_state_next = resume_state_reg;
    resumeack_next    = resumeack_reg;
    case (resume_state_reg)
      R_IDLE: begin
        if (resume_start) begin
          resume_state_next = R_REQ;
          resumeack_next    = 1'b0;
        end
      end
      R_REQ: begin
        if (dm_clear) begin
          resume_state_next = R_IDLE;
        end else if (hart_resumeack) begin
          resume_state_next = R_IDLE;
          resumeack_next    = 1'b1;
        end
      end
      default: resume_state_next = R_IDLE;
    endcase
  end

  // ------------------------------------------------- register write actions
  always_comb begin
    dmcontrol_next   = dmcontrol_reg;
    cmderr_next      = cmderr_reg;
    relaxedpriv_next = relaxedpriv_reg;
    command_next     = command_reg;
    sbcs_next        = sbcs_reg;

    if (dmcontrol_wr) begin
      if (!dmi_req_data[0]) begin
        dmcontrol_next = '0;
      end else if (!dmcontrol_reg[0]) begin
        // An inactive module only listens to dmactive.
        dmcontrol_next = 32'h0000_0001;
      end else begin
        dmcontrol_next = ((dmcontrol_reg & ~DMCONTROL_WMASK) |
                          (dmi_req_data & DMCONTROL_WMASK)) & ~DMCONTROL_WO;
      end
    end

    if (abstractcs_wr) begin
      // Only relaxedpriv (bit 11) is writable. cmderr is cleared bit by bit on 1s.
      relaxedpriv_next = dmi_req_data[11];
      cmderr_next      = cmderr_reg & ~dmi_req_data[10:8];
    end

    if (command_wr) begin
      command_next = dmi_req_data;
      // No abstract commands are implemented. The first error sticks.
      if (cmderr_reg == 3'd0) cmderr_next = 3'd2;
    end

    if (sbcs_wr) sbcs_next = (sbcs_reg & ~SBCS_WMASK) | (dmi_req_data & SBCS_WMASK);

    if (dm_clear) begin
      cmderr_next = '0;
      sbcs_next   = '0;
    end
  end

  // ------------------------------------------------------------ state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xact_state_reg   <= S_IDLE;
      resume_state_reg <= R_IDLE;
      resp_data_reg    <= '0;
      resp_op_reg      <= RESP_OK;
      resumeack_reg    <= 1'b0;
      dmcontrol_reg    <= '0;
      cmderr_reg       <= '0;
      relaxedpriv_reg  <= 1'b0;
      command_reg      <= '0;
      sbcs_reg         <= '0;
    end else begin
      xact_state_reg   <= xact_state_next;
      resume_state_reg <= resume_state_next;
      resp_data_reg    <= resp_data_next;
      resp_op_reg      <= resp_op_next;
      resumeack_reg    <= resumeack_next;
      dmcontrol_reg    <= dmcontrol_next;
      cmderr_reg       <= cmderr_next;
      relaxedpriv_reg  <= relaxedpriv_next;
      command_reg      <= command_next;
      sbcs_reg         <= sbcs_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATACOUNT; gi++) begin : g_data
      localparam logic [ABITS-1:0] ADDR = ABITS'(4 + gi);
      logic [31:0] value_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg <= '0;
        end else if (dm_clear) begin
          value_reg <= '0;
        end else if (do_write && (dmi_req_addr == ADDR)) begin
          value_reg <= dmi_req_data;
        end
      end
      assign data_q[gi] = value_reg;
    end
  endgenerate

  // ----------------------------------------------------------- outputs
  assign dmi_req_ready  = (xact_state_reg == S_IDLE);
  assign dmi_resp_valid = (xact_state_reg == S_RESP);
  assign dmi_resp_data  = resp_data_reg;
  assign dmi_resp_op    = resp_op_reg;
  assign hart_haltreq   = dmcontrol_reg[31];
  assign ndmreset       = dmcontrol_reg[1];
  assign dmactive       = dmcontrol_reg[0];
  assign hart_resumereq = (resume_state_reg == R_REQ);

endmodule

// File: tb/tb_dm_dmi_responder.sv
// tb_dm_dmi_responder
//   Self-checking bench for dm_dmi_responder. The directed sequences follow
//   the register rules for the debug module. A randomized phase then runs
//   further transactions. Every response and hart-side output is compared
//   against a field-level reference model of the debug registers.
module tb_dm_dmi_responder;

  localparam int DATACOUNT = 2;
  localparam int DMCTRL_WO_BITS [7] = '{30, 28, 27, 5, 4, 3, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [31:0] dmi_req_data;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_op;
  logic        hart_halted;
  logic        hart_running;
  logic        hart_resumeack;
  logic        hart_haltreq;
  logic        hart_resumereq;
  logic        ndmreset;
  logic        dmactive;

  always #5 clk = ~clk;

  dm_dmi_responder #(.ABITS(7), .DATACOUNT(DATACOUNT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_op     (dmi_req_op),
    .dmi_req_data   (dmi_req_data),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_op    (dmi_resp_op),
    .hart_halted    (hart_halted),
    .hart_running   (hart_running),
    .hart_resumeack (hart_resumeack),
    .hart_haltreq   (hart_haltreq),
    .hart_resumereq (hart_resumereq),
    .ndmreset       (ndmreset),
    .dmactive       (dmactive)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (field level)
  logic [31:0] m_dmcontrol;
  logic [31:0] m_data [2];
  logic [31:0] m_command;
  logic [31:0] m_sbcs;
  logic [2:0]  m_cmderr;
  logic        m_relaxedpriv;
  logic        m_resume_pending;
  logic        m_resumeack;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_dmcontrol      = '0;
    m_data[0]        = '0;
    m_data[1]        = '0;
    m_command        = '0;
    m_sbcs           = '0;
    m_cmderr         = '0;
    m_relaxedpriv    = 1'b0;
    m_resume_pending = 1'b0;
    m_resumeack      = 1'b0;
  endtask

  function automatic logic [31:0] strip_write_only(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < 7; k++) r = r & ~(32'h1 << DMCTRL_WO_BITS[k]);
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] addr);
    case (addr)
      7'h04: return m_data[0];
      7'h05: return (DATACOUNT == 2) ? m_data[1] : 32'h0;
      7'h10: return m_dmcontrol;
      7'h11: return 32'd2 | (32'd1 << 7)
                    | ({30'b0, hart_halted, hart_halted} << 8)
                    | ({30'b0, hart_running, hart_running} << 10)
                    | ({30'b0, m_resumeack, m_resumeack} << 16);
      7'h16: return 32'(DATACOUNT) | (32'(m_cmderr) << 8) | (32'(m_relaxedpriv) << 11);
      7'h17: return m_command;
      7'h38: return m_sbcs;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [6:0] addr, input logic [31:0] wdata);
    case (addr)
      7'h04: m_data[0] = wdata;
      7'h05: if (DATACOUNT == 2) m_data[1] = wdata;
      7'h10: begin
        if (!wdata[0]) begin
          m_dmcontrol      = '0;
          m_data[0]        = '0;
          m_data[1]        = '0;
          m_cmderr         = '0;
          m_sbcs           = '0;
          m_resume_pending = 1'b0;
        end else if (!m_dmcontrol[0]) begin
          m_dmcontrol = 32'h1;
        end else begin
          if (wdata[30] && !wdata[31] && hart_halted && !m_resume_pending) begin
            m_resume_pending = 1'b1;
            m_resumeack      = 1'b0;
          end
          m_dmcontrol = strip_write_only(wdata);
        end
      end
      7'h16: begin
        m_relaxedpriv = wdata[11];
        for (int b = 0; b < 3; b++)
          if (wdata[8 + b]) m_cmderr = m_cmderr & ~(3'b001 << b);
      end
      7'h17: begin
        m_command = wdata;
        if (m_cmderr == 3'd0) m_cmderr = 3'd2;
      end
      7'h38: m_sbcs = (m_sbcs & ~32'h001F_1000) | (wdata & 32'h001F_1000);
      default: ;
    endcase
  endtask

  task automatic check_hart_outputs(input string when);
    check_value({when, "_haltreq"},   32'(hart_haltreq),   32'(m_dmcontrol[31]));
    check_value({when, "_resumereq"}, 32'(hart_resumereq), 32'(m_resume_pending));
    check_value({when, "_ndmreset"},  32'(ndmreset),       32'(m_dmcontrol[1]));
    check_value({when, "_dmactive"},  32'(dmactive),       32'(m_dmcontrol[0]));
  endtask

  // One full DMI transaction. hold = cycles the response is back-pressured.
  // intrude = offer a competing write during the hold; it must be ignored.
  task automatic dmi_xact(input logic [1:0] op, input logic [6:0] addr,
                          input logic [31:0] wdata, input int hold, input bit intrude);
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
    @(negedge clk);
    check_value("req_ready_idle", 32'(dmi_req_ready), 32'd1);
    exp_data = (op == 2'd1) ? model_read(addr) : 32'h0;
    exp_op   = (op == 2'd3) ? 2'd2 : 2'd0;
    dmi_req_valid  = 1'b1;
    dmi_req_op     = op;
    dmi_req_addr   = addr;
    dmi_req_data   = wdata;
    dmi_resp_ready = 1'b0;
    @(posedge clk);
    #1;
    if (op == 2'd2) model_write(addr, wdata);
    dmi_req_valid = 1'b0;
    dmi_req_op    = 2'd0;
    check_value("resp_valid", 32'(dmi_resp_valid), 32'd1);
    check_value("req_ready_busy", 32'(dmi_req_ready), 32'd0);
    check_value("resp_data", dmi_resp_data, exp_data);
    check_value("resp_op", 32'(dmi_resp_op), 32'(exp_op));
    check_value("resumereq_accept", 32'(hart_resumereq), 32'(m_resume_pending));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (intrude) begin
        dmi_req_valid = (k < hold - 1);
        dmi_req_op    = 2'd2;
        dmi_req_addr  = 7'h04;
        dmi_req_data  = ~wdata;
      end
      check_value("hold_resp_valid", 32'(dmi_resp_valid), 32'd1);
      check_value("hold_resp_data", dmi_resp_data, exp_data);
      check_value("hold_req_ready", 32'(dmi_req_ready), 32'd0);
    end
    @(negedge clk);
    dmi_req_valid  = 1'b0;
    dmi_req_op     = 2'd0;
    dmi_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    dmi_resp_ready = 1'b0;
    check_value("resp_done", 32'(dmi_resp_valid), 32'd0);
    check_hart_outputs("post");
    $display("xact op=%0d addr=%02h wdata=%08h rdata=%08h exp=%08h resp_op=%0d hold=%0d",
             op, addr, wdata, dmi_resp_data, exp_data, dmi_resp_op, hold);
  endtask

  task automatic pulse_ack(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    hart_resumeack = 1'b1;
    @(posedge clk);
    #1;
    hart_resumeack = 1'b0;
    if (m_resume_pending) begin
      m_resume_pending = 1'b0;
      m_resumeack      = 1'b1;
    end
    check_value("resumereq_after_ack", 32'(hart_resumereq), 32'(m_resume_pending));
    $display("resumeack pulse, resumereq=%0d", hart_resumereq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] addr_tbl [8];
    logic [6:0]  a;
    logic [1:0]  op;
    logic [31:0] wd;
    int          r;

    addr_tbl = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h16, 7'h17, 7'h38, 7'h00};
    rst_n          = 1'b0;
    dmi_req_valid  = 1'b0;
    dmi_req_addr   = '0;
    dmi_req_op     = '0;
    dmi_req_data   = '0;
    dmi_resp_ready = 1'b0;
    hart_halted    = 1'b1;
    hart_running   = 1'b0;
    hart_resumeack = 1'b0;
    model_reset();

    // Reset values
    #12;
    check_value("rst_req_ready", 32'(dmi_req_ready), 32'd1);
    check_value("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
    check_value("rst_resp_data", dmi_resp_data, 32'd0);
    check_value("rst_resp_op", 32'(dmi_resp_op), 32'd0);
    check_hart_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // dmstatus after reset
    dmi_xact(2'd1, 7'h11, 32'h0, 0, 1'b0);

    // dmactive gating, then full dmcontrol write
    dmi_xact(2'd2, 7'h10, 32'hFFFF_FFFF, 0, 1'b0);
    dmi_xact(2'd1, 7'h10, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h10, 32'h8000_0003, 0, 1'b0);
    dmi_xact(2'd1, 7'h10, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h10, 32'h0000_0001, 0, 1'b0);

    // Resume handshake
    @(negedge clk);
    hart_halted = 1'b1;
    dmi_xact(2'd2, 7'h10, 32'h4000_0001, 0, 1'b0);
    pulse_ack(5);
    dmi_xact(2'd1, 7'h11, 32'h0, 0, 1'b0);

    // Abstract command error handling
    dmi_xact(2'd2, 7'h17, 32'h0022_1000, 0, 1'b0);
    dmi_xact(2'd1, 7'h16, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h16, 32'h0000_0200, 0, 1'b0);
    dmi_xact(2'd1, 7'h16, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h16, 32'h0000_0800, 0, 1'b0);
    dmi_xact(2'd1, 7'h16, 32'h0, 0, 1'b0);

    // Back-pressure with a competing request
    dmi_xact(2'd2, 7'h04, 32'hDEAD_BEEF, 0, 1'b0);
    dmi_xact(2'd1, 7'h04, 32'hDEAD_BEEF, 4, 1'b1);
    dmi_xact(2'd1, 7'h04, 32'h0, 0, 1'b0);

    // Reserved op and nop leave state alone
    dmi_xact(2'd3, 7'h10, 32'h0000_0000, 0, 1'b0);
    dmi_xact(2'd0, 7'h04, 32'h0000_0000, 0, 1'b0);
    dmi_xact(2'd1, 7'h10, 32'h0, 0, 1'b0);
    dmi_xact(2'd1, 7'h04, 32'h0, 0, 1'b0);

    // sbcs masking, then deactivation clears state
    dmi_xact(2'd2, 7'h38, 32'hFFFF_FFFF, 0, 1'b0);
    dmi_xact(2'd1, 7'h38, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h10, 32'h0000_0000, 0, 1'b0);
    dmi_xact(2'd1, 7'h04, 32'h0, 0, 1'b0);
    dmi_xact(2'd1, 7'h38, 32'h0, 0, 1'b0);
    dmi_xact(2'd2, 7'h10, 32'h0000_0001, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        hart_halted  = 1'($urandom_range(0, 1));
        hart_running = 1'($urandom_range(0, 1));
      end
      if ((m_resume_pending && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0)
        pulse_ack($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'd0 : (r <= 4) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
      a  = addr_tbl[$urandom_range(0, 7)];
      if (a == 7'h00) a = 7'($urandom_range(0, 127));
      wd = $urandom;
      if (a == 7'h10) begin
        wd[0]  = ($urandom_range(0, 7) != 0);
        wd[31] = ($urandom_range(0, 3) == 0);
        wd[30] = ($urandom_range(0, 1) == 0);
      end
      dmi_xact(op, a, wd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset asserted while a response is pending
    dmi_xact(2'd2, 7'h10, 32'h0000_0001, 0, 1'b0);
    dmi_xact(2'd2, 7'h04, 32'h1234_5678, 0, 1'b0);
    @(negedge clk);
    hart_halted = 1'b1;
    dmi_xact(2'd2, 7'h10, 32'h4000_0003, 0, 1'b0);
    @(negedge clk);
    dmi_req_valid  = 1'b1;
    dmi_req_op     = 2'd1;
    dmi_req_addr   = 7'h04;
    dmi_resp_ready = 1'b0;
    @(posedge clk);
    #1;
    dmi_req_valid = 1'b0;
    check_value("resp_before_reset", 32'(dmi_resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_value("mid_rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
    check_value("mid_rst_req_ready", 32'(dmi_req_ready), 32'd1);
    check_value("mid_rst_resp_data", dmi_resp_data, 32'd0);
    check_hart_outputs("mid_rst");
    $display("reset asserted during response, resp_valid=%0d req_ready=%0d",
             dmi_resp_valid, dmi_req_ready);
    @(negedge clk);
    rst_n = 1'b1;
    dmi_xact(2'd1, 7'h04, 32'h0, 0, 1'b0);
    dmi_xact(2'd1, 7'h10, 32'h0, 0, 1'b0);
    dmi_xact(2'd1, 7'h11, 32'h0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
